// File: rtl/uart_pkg.sv
// Shared UART FIFO types and default sizing.
// Imported by the storage array and the FIFO top.
package uart_pkg;

  localparam int unsigned DefDataWidth = 8;
  localparam int unsigned DefDepth     = 64;

  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
  } fifo_status_t;

endpackage

// File: rtl/uart_fifo_mem.sv
// Depth x DataWidth storage with synchronous write port.
// Read port is combinational with UART_FIFO_FWFT_EN, registered otherwise.
module uart_fifo_mem
  import uart_pkg::*;
#(
  parameter int unsigned DataWidth = DefDataWidth,
  parameter int unsigned Depth     = DefDepth,
  parameter int unsigned AddrWidth = $clog2(Depth)
) (
  input  logic                 i_clk,
`ifndef UART_FIFO_FWFT_EN
  input  logic                 i_rst_n,
  input  logic                 rd_en,
`endif
  input  logic                 wr_en,
  input  logic [AddrWidth-1:0] wr_addr,
  input  logic [DataWidth-1:0] wr_data,
  input  logic [AddrWidth-1:0] rd_addr,
  output logic [DataWidth-1:0] rd_data
);

  logic [DataWidth-1:0] mem [Depth];

  // Write port; storage itself is never reset.
  always_ff @(posedge i_clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

`ifdef UART_FIFO_FWFT_EN
  assign rd_data = mem[rd_addr];
`else
  // Registered read: capture the head word on a pop, hold otherwise.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end
`endif

endmodule

// File: rtl/uart_sync_fifo.sv
// Synchronous UART FIFO with sticky error flags and threshold flags.
// Define UART_FIFO_FWFT_EN for first-word-fall-through reads.
module uart_sync_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DataWidth         = DefDataWidth,
  parameter int unsigned Depth             = DefDepth,
  parameter int unsigned AlmostFullThresh  = Depth - 4,
  parameter int unsigned AlmostEmptyThresh = 4
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_wr_en,
  input  logic [DataWidth-1:0]      i_data,
  input  logic                      i_rd_en,
  input  logic                      i_clr_err,
  output logic [DataWidth-1:0]      o_data,
  output logic                      o_valid,
  output logic                      o_full,
  output logic                      o_empty,
  output logic                      o_almost_full,
  output logic                      o_almost_empty,
  output logic [$clog2(Depth):0]    o_count,
  output logic                      o_overflow,
  output logic                      o_underflow
);

  localparam int unsigned PtrWidth = $clog2(Depth);

  localparam logic [PtrWidth:0] PtrOne = 1;
  localparam logic [PtrWidth:0] AfLvl  = AlmostFullThresh[PtrWidth:0];
  localparam logic [PtrWidth:0] AeLvl  = AlmostEmptyThresh[PtrWidth:0];

  logic [PtrWidth:0]    wr_ptr;
  logic [PtrWidth:0]    rd_ptr;
  logic [PtrWidth:0]    count;
  fifo_status_t         status;
  logic                 wr_acc;
  logic                 rd_acc;
  logic [DataWidth-1:0] mem_rdata;

  assign count = wr_ptr - rd_ptr;

  // Flags come only from the registered pointers.
  always_comb begin
    status.empty = (wr_ptr == rd_ptr);
    status.full  = (wr_ptr[PtrWidth-1:0] == rd_ptr[PtrWidth-1:0]) &&
                   (wr_ptr[PtrWidth] != rd_ptr[PtrWidth]);
    status.almost_full  = (count >= AfLvl);
    status.almost_empty = (count <= AeLvl);
  end

  assign wr_acc = i_wr_en && !status.full;
  assign rd_acc = i_rd_en && !status.empty;

  // Pointer advance; reset overrides any request in the same cycle.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + PtrOne;
      if (rd_acc) rd_ptr <= rd_ptr + PtrOne;
    end
  end

  // Sticky errors: a new error in a clear cycle keeps the flag set.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_overflow  <= 1'b0;
      o_underflow <= 1'b0;
    end else begin
      o_overflow  <= (i_wr_en && status.full) ||
                     (o_overflow && !i_clr_err);
      o_underflow <= (i_rd_en && status.empty) ||
                     (o_underflow && !i_clr_err);
    end
  end

  uart_fifo_mem #(
    .DataWidth (DataWidth),
    .Depth     (Depth)
  ) u_mem (
    .i_clk   (i_clk),
`ifndef UART_FIFO_FWFT_EN
    .i_rst_n (i_rst_n),
    .rd_en   (rd_acc),
`endif
    .wr_en   (wr_acc && i_rst_n),
    .wr_addr (wr_ptr[PtrWidth-1:0]),
    .wr_data (i_data),
    .rd_addr (rd_ptr[PtrWidth-1:0]),
    .rd_data (mem_rdata)
  );

`ifdef UART_FIFO_FWFT_EN
  assign o_valid = !status.empty;
  assign o_data  = status.empty ? '0 : mem_rdata;
`else
  // One-cycle valid pulse after each accepted pop.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_valid <= 1'b0;
    end else begin
      o_valid <= rd_acc;
    end
  end

  assign o_data = mem_rdata;
`endif

  assign o_full         = status.full;
  assign o_empty        = status.empty;
  assign o_almost_full  = status.almost_full;
  assign o_almost_empty = status.almost_empty;
  assign o_count        = count;

endmodule

// File: tb/tb_uart_sync_fifo.sv
// Directed bench for uart_sync_fifo (Depth 4) with a queue model.
// Works in both read modes via UART_FIFO_FWFT_EN.
module tb_uart_sync_fifo;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wr_en;
  logic [7:0] din;
  logic       rd_en;
  logic       clr;
  logic [7:0] dout;
  logic       valid;
  logic       full;
  logic       empty;
  logic       afull;
  logic       aempty;
  logic [2:0] count;
  logic       ovf;
  logic       udf;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  logic [7:0] q[$];
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_ovf;
  logic       m_udf;

  always #5 clk = ~clk;

  uart_sync_fifo #(
    .DataWidth         (8),
    .Depth             (4),
    .AlmostFullThresh  (3),
    .AlmostEmptyThresh (1)
  ) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_wr_en        (wr_en),
    .i_data         (din),
    .i_rd_en        (rd_en),
    .i_clr_err      (clr),
    .o_data         (dout),
    .o_valid        (valid),
    .o_full         (full),
    .o_empty        (empty),
    .o_almost_full  (afull),
    .o_almost_empty (aempty),
    .o_count        (count),
    .o_overflow     (ovf),
    .o_underflow    (udf)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Queue model of occupancy, errors and read data.
  always @(posedge clk) begin
    bit is_full, is_empty, wa, ra;
    if (!rst_n) begin
      q.delete();
      m_data  = 8'h00;
      m_valid = 1'b0;
      m_ovf   = 1'b0;
      m_udf   = 1'b0;
    end else begin
      is_full  = (q.size() == 4);
      is_empty = (q.size() == 0);
      wa = wr_en && !is_full;
      ra = rd_en && !is_empty;
      m_ovf = (wr_en && is_full) || (m_ovf && !clr);
      m_udf = (rd_en && is_empty) || (m_udf && !clr);
      m_valid = ra;
      if (ra) begin
        m_data = q[0];
        void'(q.pop_front());
      end
      if (wa) q.push_back(din);
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("count", count, q.size());
      chk("empty", empty, q.size() == 0);
      chk("full", full, q.size() == 4);
      chk("afull", afull, q.size() >= 3);
      chk("aempty", aempty, q.size() <= 1);
      chk("ovf", ovf, m_ovf);
      chk("udf", udf, m_udf);
`ifdef UART_FIFO_FWFT_EN
      chk("valid", valid, q.size() != 0);
      chk("data", dout, (q.size() != 0) ? q[0] : 8'h00);
`else
      chk("valid", valid, m_valid);
      chk("data", dout, m_data);
`endif
    end
  end

  task automatic step(input logic w, input logic [7:0] d,
                      input logic r, input logic c);
    wr_en = w;
    din   = d;
    rd_en = r;
    clr   = c;
    @(negedge clk);
  endtask

  // Pop one word (optionally pushing d) and check the popped value.
  task automatic xfer(input logic w, input logic [7:0] d,
                      input logic [7:0] exp);
`ifdef UART_FIFO_FWFT_EN
    chk("pop_valid", valid, 1);
    chk("pop_data", dout, exp);
    step(w, d, 1'b1, 1'b0);
`else
    step(w, d, 1'b1, 1'b0);
    chk("pop_valid", valid, 1);
    chk("pop_data", dout, exp);
`endif
  endtask

  initial begin
    rst_n = 1'b0;
    wr_en = 1'b0;
    din   = 8'h00;
    rd_en = 1'b0;
    clr   = 1'b0;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_aempty", aempty, 1);
    chk("rst_valid", valid, 0);
    chk("rst_data", dout, 0);
    rst_n = 1'b1;

    step(1'b1, 8'hA1, 1'b0, 1'b0);
    chk("cnt1", count, 1);
    step(1'b1, 8'hB2, 1'b0, 1'b0);
    chk("cnt2", count, 2);
    chk("af_at2", afull, 0);
    step(1'b1, 8'hC3, 1'b0, 1'b0);
    chk("cnt3", count, 3);
    chk("af_at3", afull, 1);
    step(1'b1, 8'hD4, 1'b0, 1'b0);
    chk("cnt4", count, 4);
    chk("full4", full, 1);

    step(1'b1, 8'hEE, 1'b0, 1'b0);
    chk("ovf_set", ovf, 1);
    chk("ovf_cnt", count, 4);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    chk("ovf_hold", ovf, 1);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("ovf_clr", ovf, 0);
    step(1'b0, 8'h00, 1'b0, 1'b0);

    xfer(1'b0, 8'h00, 8'hA1);
    step(1'b0, 8'h00, 1'b0, 1'b0);
`ifndef UART_FIFO_FWFT_EN
    chk("pulse_one", valid, 0);
`endif
    xfer(1'b0, 8'h00, 8'hB2);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    xfer(1'b0, 8'h00, 8'hC3);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    xfer(1'b0, 8'h00, 8'hD4);
    chk("empty_end", empty, 1);

    step(1'b1, 8'h11, 1'b0, 1'b0);
    step(1'b1, 8'h22, 1'b0, 1'b0);
    xfer(1'b1, 8'h55, 8'h11);
    chk("cnt_rw", count, 2);
    xfer(1'b1, 8'h66, 8'h22);
    xfer(1'b1, 8'h77, 8'h55);
    chk("cnt_rw2", count, 2);
    xfer(1'b0, 8'h00, 8'h66);
    xfer(1'b0, 8'h00, 8'h77);
    chk("empty_wrap", empty, 1);

    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("udf_set", udf, 1);
    chk("udf_valid", valid, 0);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("udf_clr", udf, 0);
    step(1'b1, 8'h99, 1'b0, 1'b0);
    xfer(1'b0, 8'h00, 8'h99);

    step(1'b0, 8'h00, 1'b1, 1'b1);
    chk("set_wins", udf, 1);
    step(1'b0, 8'h00, 1'b0, 1'b1);

`ifdef UART_FIFO_FWFT_EN
    step(1'b1, 8'h3C, 1'b0, 1'b0);
    chk("fwft_valid", valid, 1);
    chk("fwft_data", dout, 8'h3C);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("fwft_pop", valid, 0);
`endif

    step(1'b1, 8'h42, 1'b0, 1'b0);
    rst_n = 1'b0;
    step(1'b1, 8'h43, 1'b1, 1'b0);
    chk("rst2_count", count, 0);
    chk("rst2_empty", empty, 1);
    rst_n = 1'b1;
    step(1'b0, 8'h00, 1'b0, 1'b0);

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
